spi_reg_responder: RTL and testbench
====================================

# spi_reg_responder

Register-file responder for the board SPI link: the far end of the FPGA's SPI read/write initiators. It oversamples an incoming `spi_clk`/`serial_in` pair on the system clock and captures an address byte. It then shifts register bytes out on `serial_out`, auto-incrementing, and, when write support is compiled in, shifts bytes in. Used as an on-FPGA emulation target for ASIC register banks and as the loopback target in initiator benches.

## Interface
Parameters:
- `REG_WIDTH`, 8, bits per register and per address byte.
- `NUM_REGS`, 32, registers implemented (addresses 0..NUM_REGS-1).
- `IDLE_CYCLES`, 16, `clk` cycles without an `spi_clk` edge that end a frame.

Ports:
- `clk` in 1: system clock; must be at least 4x the `spi_clk` frequency.
- `rst` in 1: synchronous, active-high reset.
- `spi_clk` in 1: initiator clock, asynchronous to `clk`, idles low.
- `serial_in` in 1: initiator-to-responder data.
- `serial_out` out 1: responder-to-initiator data.
- `loc_wr_en` in 1: local register write strobe.
- `loc_wr_addr` in REG_WIDTH: local write address.
- `loc_wr_data` in REG_WIDTH: local write data.
- `busy` out 1: a frame is in progress (state not IDLE).
- `byte_done` out 1: one-cycle pulse per completed data byte.
- `frame_done` out 1: one-cycle pulse on the idle timeout that ends a frame.
- `addr_err` out 1: one-cycle pulse when a data byte targets an address ≥ NUM_REGS.

## Operation
- `spi_clk` and `serial_in` each pass through a 2-FF synchronizer. Rise and fall are edge-detected on the synchronized clock. Sampling uses the synchronized data aligned with the edge.
- State machine:
  - IDLE to ADDR on the first detected rise.
  - ADDR: shifts `serial_in` in MSB-first on each rise. After REG_WIDTH rises it latches `addr` and goes to DATA.
  - DATA to IDLE after IDLE_CYCLES consecutive cycles with no edge. The idle counter also runs in ADDR; a partial address is discarded.
- Read data:
  - `tx_shift` loads `reg[addr]` (0 if out of range) on the fall following the last address rise. `serial_out` = `tx_shift` MSB.
  - Each later fall shifts left by one.
  - After REG_WIDTH data falls: `addr` increments modulo 2^REG_WIDTH, `tx_shift` reloads, and `byte_done` pulses.
  - Reads have no length limit; the initiator ends the frame.
- Out-of-range addresses: read 0x00, writes are dropped, and `addr_err` pulses with that byte's `byte_done`.
- Local writes take effect on the next `clk`. A byte already in `tx_shift` is not altered.
- Reset values:
  - `serial_out` 0, `busy` 0, all pulses 0.
  - State IDLE, counters 0, all registers 0.
- `rst` mid-frame aborts immediately; the next rise starts a fresh ADDR.

## Timing
- Edge-to-action latency: 3 `clk` (2 sync + 1 detect).
- `serial_out` is stable from 3 `clk` after a fall until 3 `clk` after the next fall. This requires `clk` ≥ 4x `spi_clk`.
- `byte_done` and `addr_err` are asserted for exactly 1 `clk`.
- `frame_done` pulses in the cycle the idle counter reaches IDLE_CYCLES. `busy` drops the next cycle.
- A local write and an SPI write to the same address in the same cycle: the SPI write wins.

## Configuration
- `SPI_RESP_WRITE_EN` defined:
  - Address-byte MSB = 1 selects write; the low REG_WIDTH-1 bits are the address.
  - In a write frame, DATA shifts `serial_in` in on rises; each full byte is written to `reg[addr]` and `addr` increments.
  - `serial_out` is held at 0 during write frames.
- Not defined:
  - All frames are reads and the full address byte is the address.
  - No SPI write path exists; registers change only through the local port.

## Structure
- Shared package `spi_pkg`: `resp_state_t` enum (IDLE, ADDR, DATA), `SPI_SYNC_STAGES = 2`, and the write-flag bit-position constant.
- Sub-module `spi_resp_sync` holds the synchronizers and edge detect. Outputs: `sclk_rise`, `sclk_fall`, `sdi_sync`.

## Test plan
- Local-write reg[3]=0xA5 and reg[4]=0x3C; initiator reads 2 from 0x03 -> `serial_out` 10100101 then 00111100; two `byte_done` pulses; one `frame_done`.
- Read 3 from `NUM_REGS`-1 -> reg[31], 0x00, 0x00; `addr_err` on bytes 2 and 3.
- Initiator stops after 5 address bits, idle for IDLE_CYCLES, then a full read of 0x00 -> reg[0] returned; no `byte_done` for the aborted frame.
- `SPI_RESP_WRITE_EN`: write frame 0x85, 0x11, 0x22 -> reg[5]=0x11, reg[6]=0x22; a subsequent read returns the same.
- Assert `rst` mid-DATA on byte 1 -> `serial_out`=0, `busy`=0 next cycle; a following read of 0x03 is correct.
- Same-cycle local and SPI write to reg[2] (local 0x55, SPI 0xAA) -> reg[2]=0xAA.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder.
//   resp_state_t       : responder frame state (IDLE, ADDR, DATA)
//   SPI_SYNC_STAGES    : flip-flops in each spi_clk / serial_in synchronizer
//   SPI_WR_FLAG_OFFSET : the write flag sits at bit (REG_WIDTH - SPI_WR_FLAG_OFFSET)
//                        of the address byte, i.e. its MSB
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } resp_state_t;

  localparam int SPI_SYNC_STAGES    = 2;
  localparam int SPI_WR_FLAG_OFFSET = 1;
endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI bus between an initiator (master) and the register responder (slave).
//   spi_clk    : initiator clock, idles low
//   serial_in  : initiator-to-responder data
//   serial_out : responder-to-initiator data
// Handshake: there is no valid/ready pair on this bus. The initiator owns
// spi_clk; the responder samples serial_in on rising spi_clk and updates
// serial_out after falling spi_clk, each seen through its clk-domain synchronizer.
interface spi_reg_responder_if;
  logic spi_clk;
  logic serial_in;
  logic serial_out;

  modport master (output spi_clk, output serial_in, input serial_out);
  modport slave  (input spi_clk, input serial_in, output serial_out);
endinterface

// File: rtl/spi_resp_sync.sv
// Brings spi_clk and serial_in into the clk domain and edge-detects spi_clk.
//   clk, rst   : system clock, synchronous active-high reset
//   spi_clk    : asynchronous initiator clock
//   serial_in  : asynchronous initiator data
//   sclk_rise  : one-cycle strobe, synchronized spi_clk went 0->1
//   sclk_fall  : one-cycle strobe, synchronized spi_clk went 1->0
//   sdi_sync   : serial_in after the same number of stages as spi_clk, so it
//                lines up with the rise strobe
module spi_resp_sync
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic serial_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sdi_sync
);
  localparam int S = SPI_SYNC_STAGES;

  logic [S-1:0] sclk_q;
  logic [S-1:0] sdi_q;
  logic         sclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= '0;
      sdi_q       <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[S-2:0], spi_clk};
      sdi_q       <= {sdi_q[S-2:0], serial_in};
      sclk_prev_q <= sclk_q[S-1];
    end
  end

  assign sclk_rise = sclk_q[S-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[S-1] & sclk_prev_q;
  assign sdi_sync  = sdi_q[S-1];
endmodule

// File: rtl/spi_reg_responder.sv
// SPI register-file responder. Captures an address byte, then streams
// registers out MSB-first with auto-increment until the initiator goes idle.
// Optional build macro: SPI_RESP_WRITE_EN (address MSB selects a write frame,
// data bytes shifted in are written to the register file).
//   clk, rst      : system clock (>= 4x spi_clk), synchronous active-high reset
//   spi           : SPI bus, slave modport
//   loc_wr_*      : local register write port, takes effect on the next clk
//   busy          : frame in progress (state not IDLE)
//   byte_done     : one-cycle pulse per completed data byte
//   frame_done    : one-cycle pulse when the idle timeout ends a frame
//   addr_err      : pulses with byte_done when that byte's address >= NUM_REGS
//   dbg_state     : current frame state
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int REG_WIDTH   = 8,
  parameter int NUM_REGS    = 32,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_responder_if.slave   spi,
  input  logic                 loc_wr_en,
  input  logic [REG_WIDTH-1:0] loc_wr_addr,
  input  logic [REG_WIDTH-1:0] loc_wr_data,
  output logic                 busy,
  output logic                 byte_done,
  output logic                 frame_done,
  output logic                 addr_err,
  output resp_state_t          dbg_state
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(REG_WIDTH + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(REG_WIDTH - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_END  = IW'(IDLE_CYCLES);

  logic sclk_rise, sclk_fall, sdi_sync;

  spi_resp_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi.spi_clk),
    .serial_in(spi.serial_in),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .sdi_sync (sdi_sync)
  );

  resp_state_t          state_q;
  logic [REG_WIDTH-1:0] rx_q, tx_q, addr_q;
  logic [CW-1:0]        bit_q;
  logic [IW-1:0]        idle_q;
  logic                 tx_armed_q;  // first data byte loaded into tx_q
  logic                 byte_done_q, frame_done_q, addr_err_q;
  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
`ifdef SPI_RESP_WRITE_EN
  logic                 wr_mode_q;
`endif

  logic [REG_WIDTH-1:0] rx_d, addr_inc, rd_cur, rd_next;

  function automatic logic in_range(input logic [REG_WIDTH-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  assign rx_d     = {rx_q[REG_WIDTH-2:0], sdi_sync};
  assign addr_inc = addr_q + 1'b1;
  assign rd_cur   = in_range(addr_q)   ? regs_q[addr_q[AW-1:0]]   : '0;
  assign rd_next  = in_range(addr_inc) ? regs_q[addr_inc[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      bit_q        <= '0;
      idle_q       <= '0;
      tx_armed_q   <= 1'b0;
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
      wr_mode_q    <= 1'b0;
`endif
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      addr_err_q   <= 1'b0;

      // Local write first so a same-cycle SPI write below overrides it.
      if (loc_wr_en && in_range(loc_wr_addr)) regs_q[loc_wr_addr[AW-1:0]] <= loc_wr_data;

      case (state_q)
        IDLE: begin
          if (sclk_rise) begin
            state_q <= ADDR;
            rx_q    <= rx_d;
            bit_q   <= CW'(1);
            idle_q  <= '0;
          end
        end
        ADDR, DATA: begin
          if (idle_q == IDLE_END) begin
            // frame_done was shown last cycle; close the frame now.
            state_q    <= IDLE;
            rx_q       <= '0;
            tx_q       <= '0;
            bit_q      <= '0;
            idle_q     <= '0;
            tx_armed_q <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
            wr_mode_q  <= 1'b0;
`endif
          end else begin
            if (sclk_rise || sclk_fall) begin
              idle_q <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
              if (idle_q == IDLE_LAST) frame_done_q <= 1'b1;
            end

            if (state_q == ADDR) begin
              if (sclk_rise) begin
                rx_q <= rx_d;
                if (bit_q == LAST_BIT) begin
                  state_q    <= DATA;
                  bit_q      <= '0;
                  tx_armed_q <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
                  wr_mode_q  <= rx_d[REG_WIDTH-SPI_WR_FLAG_OFFSET];
                  addr_q     <= {1'b0, rx_d[REG_WIDTH-2:0]};
`else
                  addr_q     <= rx_d;
`endif
                end else begin
                  bit_q <= bit_q + 1'b1;
                end
              end
            end else begin
`ifdef SPI_RESP_WRITE_EN
              if (wr_mode_q) begin
                if (sclk_rise) begin
                  rx_q <= rx_d;
                  if (bit_q == LAST_BIT) begin
                    bit_q       <= '0;
                    addr_q      <= addr_inc;
                    byte_done_q <= 1'b1;
                    if (in_range(addr_q)) regs_q[addr_q[AW-1:0]] <= rx_d;
                    else                  addr_err_q <= 1'b1;
                  end else begin
                    bit_q <= bit_q + 1'b1;
                  end
                end
              end else
`endif
              if (sclk_fall) begin
                if (!tx_armed_q) begin
                  // Fall after the last address rise: present the first byte.
                  tx_q       <= rd_cur;
                  tx_armed_q <= 1'b1;
                  bit_q      <= '0;
                end else if (bit_q == LAST_BIT) begin
                  tx_q        <= rd_next;
                  bit_q       <= '0;
                  addr_q      <= addr_inc;
                  byte_done_q <= 1'b1;
                  addr_err_q  <= ~in_range(addr_q);
                end else begin
                  tx_q  <= tx_q << 1;
                  bit_q <= bit_q + 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_RESP_WRITE_EN
  assign spi.serial_out = tx_q[REG_WIDTH-1] & ~wr_mode_q;
`else
  assign spi.serial_out = tx_q[REG_WIDTH-1];
`endif
  assign busy       = (state_q != IDLE);
  assign byte_done  = byte_done_q;
  assign frame_done = frame_done_q;
  assign addr_err   = addr_err_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: the initiator is driven bit by bit from tasks,
// expected read bytes {addr_err, data} are queued as each frame is issued, and
// a monitor assembles serial_out on every spi_clk rise and pops/compares on
// each byte_done pulse.
module tb_spi_reg_responder;
  import spi_pkg::*;

  localparam int H = 5;  // clk cycles per spi_clk half period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_responder_if bus ();
  logic        loc_wr_en;
  logic [7:0]  loc_wr_addr, loc_wr_data;
  logic        busy, byte_done, frame_done, addr_err;
  resp_state_t dbg_state;

  spi_reg_responder #(.REG_WIDTH(8), .NUM_REGS(32), .IDLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (bus),
    .loc_wr_en  (loc_wr_en),
    .loc_wr_addr(loc_wr_addr),
    .loc_wr_data(loc_wr_data),
    .busy       (busy),
    .byte_done  (byte_done),
    .frame_done (frame_done),
    .addr_err   (addr_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];  // {addr_err, data}
  int checks = 0;
  int passes = 0;
  int bd_cnt = 0;
  int fd_cnt = 0;
  logic [7:0] mon_sr = '0;
  logic [8:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // serial_out as the initiator sees it at each spi_clk rise
  initial forever begin
    @(posedge bus.spi_clk);
    mon_sr = {mon_sr[6:0], bus.serial_out};
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (addr_err && !byte_done) begin
      checks++;
      $display("FAIL addr_err_alone: actual 1 required 0");
    end
    if (byte_done) begin
      bd_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_byte_done: actual byte %0h required none", mon_sr);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_byte", {24'b0, mon_sr}, {24'b0, mon_e[7:0]});
        check("addr_err", {31'b0, addr_err}, {31'b0, mon_e[8]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    bus.serial_in = b;
    repeat (H) wait_clk;
    bus.spi_clk = 1'b1;
    repeat (H) wait_clk;
    bus.spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic local_wr(input logic [7:0] a, input logic [7:0] d);
    loc_wr_en   = 1'b1;
    loc_wr_addr = a;
    loc_wr_data = d;
    wait_clk;
    loc_wr_en   = 1'b0;
  endtask

  task automatic frame_end(input string name);
    int n = 0;
    while (busy && n < 200) begin
      wait_clk;
      n++;
    end
    check(name, {31'b0, busy}, 32'd0);
    repeat (4) wait_clk;
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic read_frame(input logic [7:0] a, input int n);
    spi_byte(a);
    for (int i = 0; i < n; i++) spi_byte(8'h00);
    frame_end("read_end");
  endtask

  // ---------------- stimulus ----------------
  int fd0, bd0;
  initial begin
    rst = 1'b1;
    bus.spi_clk = 1'b0;
    bus.serial_in = 1'b0;
    loc_wr_en = 1'b0;
    loc_wr_addr = '0;
    loc_wr_data = '0;
    repeat (3) wait_clk;
    check("rst_serial_out", {31'b0, bus.serial_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pulses", {29'b0, byte_done, frame_done, addr_err}, 32'd0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    wait_clk;

    local_wr(8'h03, 8'hA5);
    local_wr(8'h04, 8'h3C);
    local_wr(8'h1F, 8'hE7);
    local_wr(8'h00, 8'h5A);

    // Two-byte read from 0x03, one frame_done.
    fd0 = fd_cnt;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h3C});
    read_frame(8'h03, 2);
    check("t1_frame_done", fd_cnt - fd0, 32'd1);

    // Read across the top of the register file.
    exp_q.push_back({1'b0, 8'hE7});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    read_frame(8'h1F, 3);

    // Aborted address, then a clean read of 0x00.
    bd0 = bd_cnt;
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    frame_end("abort_end");
    check("abort_no_byte_done", bd_cnt - bd0, 32'd0);
    exp_q.push_back({1'b0, 8'h5A});
    read_frame(8'h00, 1);

`ifdef SPI_RESP_WRITE_EN
    // Write frame to 0x05/0x06, then read back.
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h00});
    spi_byte(8'h85);
    spi_byte(8'h11);
    spi_byte(8'h22);
    frame_end("wr_end");
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    read_frame(8'h05, 2);

    // Local 0x55 lands in the same cycle as the SPI write of 0xAA to reg[2].
    exp_q.push_back({1'b0, 8'h00});
    spi_byte(8'h82);
    for (int i = 7; i >= 1; i--) spi_bit(((8'hAA >> i) & 8'h01) != 8'h00);
    bus.serial_in = 1'b0;
    repeat (H) wait_clk;
    bus.spi_clk = 1'b1;
    wait_clk;
    wait_clk;
    loc_wr_en   = 1'b1;
    loc_wr_addr = 8'h02;
    loc_wr_data = 8'h55;
    wait_clk;
    loc_wr_en   = 1'b0;
    repeat (H - 3) wait_clk;
    bus.spi_clk = 1'b0;
    frame_end("collide_end");
    exp_q.push_back({1'b0, 8'hAA});
    read_frame(8'h02, 1);
`else
    // Address 0xFF is out of range and wraps to 0x00.
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h5A});
    read_frame(8'hFF, 2);
`endif

    // Reset in the middle of the first data byte of a read of 0x03.
    spi_byte(8'h03);
    spi_bit(1'b0);
    spi_bit(1'b0);
    repeat (H) wait_clk;
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_state", dbg_state, DATA);
    check("mid_serial_out", {31'b0, bus.serial_out}, 32'd1);  // 0xA5 << 2
    rst = 1'b1;
    wait_clk;
    check("abort_serial_out", {31'b0, bus.serial_out}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_state", dbg_state, IDLE);
    rst = 1'b0;
    wait_clk;
    local_wr(8'h03, 8'h77);
    exp_q.push_back({1'b0, 8'h77});
    exp_q.push_back({1'b0, 8'h00});  // reg[4] cleared by reset
    read_frame(8'h03, 2);

    repeat (5) wait_clk;
    check("final_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
